bypass_bcast: RTL

//  Producer end of the bypass network. Collects completed results (phys-reg idx + data)

---
 rtl/bypass_bcast.sv | 104 ++++++++++
 1 files changed

// File: rtl/bypass_bcast.sv
// Bypass broadcast: arbitrates FU writeback results onto a registered
// DEPTH-slot bypass bus with round-robin fairness and duplicate detection.
module bypass_bcast #(
  parameter int  NUM_SRC  = 6,
  parameter int  DEPTH    = 4,
  parameter int  IDXWIDTH = $clog2(128),
  parameter type dtype    = logic [63:0]
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_flush,
  input  logic [NUM_SRC-1:0]  i_src_vld,
  output logic [NUM_SRC-1:0]  o_src_rdy,
  input  logic [IDXWIDTH-1:0] i_src_idx [NUM_SRC],
  input  dtype                i_src_data [NUM_SRC],
  output logic [DEPTH-1:0]    o_bypass_vld,
  output logic [IDXWIDTH-1:0] o_bypass_idx [DEPTH],
  output dtype                o_bypass_data [DEPTH],
  output logic                o_dup_err
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]       ptr;
  logic [PW-1:0]       ptr_nxt;
  logic [PW-1:0]       scan;
  logic [PW-1:0]       last;
  logic [CW-1:0]       cnt;
  logic                any;
  logic                dup;
  logic [NUM_SRC-1:0]  grant;
  logic [DEPTH-1:0]    vld_nxt;
  logic [IDXWIDTH-1:0] idx_nxt [DEPTH];
  dtype                data_nxt [DEPTH];

  // Round-robin scan from ptr; the n-th grant packs into slot n.
  always_comb begin
    grant    = '0;
    vld_nxt  = '0;
    idx_nxt  = o_bypass_idx;
    data_nxt = o_bypass_data;
    cnt      = '0;
    last     = ptr;
    any      = 1'b0;
    scan     = ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!rst && !i_flush && i_src_vld[scan] &&
          cnt < CW'(DEPTH)) begin
        grant[scan] = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
          if (cnt == CW'(k)) begin
            vld_nxt[k]  = 1'b1;
            idx_nxt[k]  = i_src_idx[scan];
            data_nxt[k] = i_src_data[scan];
          end
        end
        cnt  = cnt + CW'(1);
        last = scan;
        any  = 1'b1;
      end
      scan = (scan == PW'(NUM_SRC - 1)) ? '0 : scan + PW'(1);
    end
  end

  always_comb begin
    dup = 1'b0;
    for (int a = 0; a < NUM_SRC; a++) begin
      for (int b = a + 1; b < NUM_SRC; b++) begin
        if (grant[a] && grant[b] &&
            i_src_idx[a] == i_src_idx[b])
          dup = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if (any)
      ptr_nxt = (last == PW'(NUM_SRC - 1)) ? '0 : last + PW'(1);
  end

  assign o_src_rdy = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_bypass_vld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        o_bypass_idx[k]  <= '0;
        o_bypass_data[k] <= '0;
      end
      o_dup_err <= 1'b0;
      ptr       <= '0;
    end else begin
      o_bypass_vld  <= vld_nxt;
      o_bypass_idx  <= idx_nxt;
      o_bypass_data <= data_nxt;
      ptr           <= ptr_nxt;
      if (dup)
        o_dup_err <= 1'b1;
    end
  end

endmodule
